// File: rtl/id_ex_stage.sv
// id_ex_stage: decode->execute pipeline register with operand forwarding, load-use stall and flush bubbles
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [3:0]        id_ra1,
    input  logic [3:0]        id_ra2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [3:0]        id_wa,
    input  logic              id_regwrite,
    input  logic              id_memtoreg,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush_e,
    input  logic              mem_regwrite,
    input  logic [3:0]        mem_wa,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regwrite,
    input  logic [3:0]        wb_wa,
    input  logic [DATA_W-1:0] wb_result,
    output logic              stall_d,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_srca,
    output logic [DATA_W-1:0] ex_srcb,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [3:0]        ex_wa,
    output logic              ex_regwrite,
    output logic              ex_memtoreg,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    logic              lu, bubble;
    logic              ex_valid_q, ex_valid_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memtoreg_q, ex_memtoreg_d;
    logic [3:0]        ex_wa_q, ex_wa_d;
    logic [3:0]        ex_ra1_q, ex_ra1_d;
    logic [3:0]        ex_ra2_q, ex_ra2_d;
    logic [DATA_W-1:0] ex_op1_q, ex_op1_d;
    logic [DATA_W-1:0] ex_op2_q, ex_op2_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    // Load-use detection, bubble insertion, capture-time WB bypass and saturating bubble counters
    always_comb begin
        lu = ex_valid_q & ex_regwrite_q & ex_memtoreg_q & (ex_wa_q != 4'd15) & id_valid &
             ((id_use1 & (id_ra1 == ex_wa_q)) | (id_use2 & (id_ra2 == ex_wa_q)));
        bubble        = flush_e | lu;
        stall_d       = lu & ~flush_e & ~reset;
        ex_valid_d    = ~bubble & id_valid;
        ex_regwrite_d = ~bubble & id_valid & id_regwrite;
        ex_memtoreg_d = ~bubble & id_valid & id_memtoreg;
        ex_ctrl_d     = bubble ? '0 : id_ctrl;
        ex_wa_d       = id_wa;
        ex_ra1_d      = id_ra1;
        ex_ra2_d      = id_ra2;
        ex_op1_d      = (wb_regwrite && wb_wa == id_ra1 && id_ra1 != 4'd15) ? wb_result : id_rd1;
        ex_op2_d      = (wb_regwrite && wb_wa == id_ra2 && id_ra2 != 4'd15) ? wb_result : id_rd2;
        stall_cnt_d   = (lu && !flush_e && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d   = (flush_e && id_valid && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    // EX operand forwarding: MEM result wins over WB result, R15 is never forwarded
    always_comb begin
        fwd_a = (mem_regwrite && mem_wa == ex_ra1_q && ex_ra1_q != 4'd15) ? 2'b10 :
                (wb_regwrite && wb_wa == ex_ra1_q && ex_ra1_q != 4'd15) ? 2'b01 : 2'b00;
        fwd_b = (mem_regwrite && mem_wa == ex_ra2_q && ex_ra2_q != 4'd15) ? 2'b10 :
                (wb_regwrite && wb_wa == ex_ra2_q && ex_ra2_q != 4'd15) ? 2'b01 : 2'b00;
        ex_srca     = fwd_a[1] ? mem_result : fwd_a[0] ? wb_result : ex_op1_q;
        ex_srcb     = fwd_b[1] ? mem_result : fwd_b[0] ? wb_result : ex_op2_q;
        ex_valid    = ex_valid_q;
        ex_wa       = ex_wa_q;
        ex_regwrite = ex_regwrite_q;
        ex_memtoreg = ex_memtoreg_q;
        ex_ctrl     = ex_ctrl_q;
        stall_cnt   = stall_cnt_q;
        flush_cnt   = flush_cnt_q;
    end

    // Pipeline register; reset clears every EX field and both counters
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_memtoreg_q <= 1'b0;
            ex_wa_q       <= '0;
            ex_ra1_q      <= '0;
            ex_ra2_q      <= '0;
            ex_op1_q      <= '0;
            ex_op2_q      <= '0;
            ex_ctrl_q     <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memtoreg_q <= ex_memtoreg_d;
            ex_wa_q       <= ex_wa_d;
            ex_ra1_q      <= ex_ra1_d;
            ex_ra2_q      <= ex_ra2_d;
            ex_op1_q      <= ex_op1_d;
            ex_op2_q      <= ex_op2_d;
            ex_ctrl_q     <= ex_ctrl_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end
endmodule
